// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader slice.
//   ldr_state_e    : loader FSM states
//   HDR_BYTES      : bytes in the little-endian word-count header
//   BYTES_PER_WORD : bytes packed into each program word
package loader_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } ldr_state_e;

    localparam int unsigned HDR_BYTES      = 4;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and memory write port of the program loader.
//   in_valid/in_data/in_ready : byte stream, transfer on in_valid && in_ready
//   memEn/memAddr/memData     : one-cycle write strobe, byte address, word
// slave  : the loader side
// master : the stream source / memory side
interface program_loader_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             memEn;
    logic [WIDTH-1:0] memAddr;
    logic [WIDTH-1:0] memData;

    modport slave  (input  in_valid, in_data, output in_ready, memEn, memAddr, memData);
    modport master (output in_valid, in_data, input  in_ready, memEn, memAddr, memData);
endinterface

// File: rtl/program_loader_byte_packer.sv
// Little-endian byte to word assembler.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : discard any partially packed word
//   load         : byteIn is accepted this cycle
//   byteIn       : incoming byte
//   word         : packed word including the byte being loaded this cycle
//   wordValid    : this load completes a word (word is then complete)
module byte_packer
    import loader_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [7:0]       byteIn,
    output logic [WIDTH-1:0] word,
    output logic             wordValid
);
    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] byteIdx;
    logic [WIDTH-1:0] shadow;

    // word is combinational so the top can register a complete word on the
    // same edge that accepts its last byte.
    always_comb begin
        word = shadow;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (load && byteIdx == IDX_W'(i)) begin
                word[i*8 +: 8] = byteIn;
            end
        end
    end

    assign wordValid = load && (byteIdx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            byteIdx <= '0;
        end else if (clear) begin
            shadow  <= '0;
            byteIdx <= '0;
        end else if (load) begin
            if (wordValid) begin
                shadow  <= '0;
                byteIdx <= '0;
            end else begin
                shadow  <= word;
                byteIdx <= byteIdx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/program_loader.sv
// Program loader: receives <word count><program words> as a byte stream,
// writes the words into processor memory, holds the core in reset during the
// load, then releases it and watches a0 for a pass value or a cycle timeout.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : byte stream in, memory write port out (slave modport)
//   cpu_reset    : processor reset, high until the run starts
//   a0           : processor a0, sampled only while running
//   expected_a0  : a0 value that marks a successful run
//   done/pass/timeout/error : sticky status flags
//   cycles       : run cycles since cpu_reset fell
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned     WIDTH          = 32,
    parameter logic [WIDTH-1:0] ADDR_BASE     = '0,
    parameter int unsigned     MAX_WORDS      = 1024,
    parameter int unsigned     RESET_HOLD     = 2,
    parameter int unsigned     TIMEOUT_CYCLES = 5000
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.slave  bus,
    output logic             cpu_reset,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] expected_a0,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             error,
    output logic [31:0]      cycles
);
    localparam int unsigned WIDX_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 2);

    ldr_state_e        state;
    logic [WIDTH-1:0]  wordCount;
    logic [WIDX_W-1:0] wordIdx;
    logic [HOLD_W-1:0] holdCnt;
    logic              accept;
    logic [WIDTH-1:0]  packWord;
    logic              packValid;

    // in_ready depends on state only, so nothing from in_valid reaches memEn
    // combinationally and no byte is taken during the WRITE cycle.
    always_comb begin
        bus.in_ready = (state == HDR) || (state == LOAD);
        cpu_reset    = !((state == RUN) || (state == DONE));
    end

    assign accept = bus.in_valid && bus.in_ready;

    byte_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == HOLD),
        .load      (accept),
        .byteIn    (bus.in_data),
        .word      (packWord),
        .wordValid (packValid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= HDR;
            bus.memEn   <= 1'b0;
            bus.memAddr <= '0;
            bus.memData <= '0;
            wordCount   <= '0;
            wordIdx     <= '0;
            holdCnt     <= '0;
            cycles      <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                HDR: begin
                    if (packValid) begin
                        wordCount <= packWord;
                        if (packWord == '0 || packWord > WIDTH'(MAX_WORDS)) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (packValid) begin
                        bus.memEn   <= 1'b1;
                        bus.memAddr <= ADDR_BASE + (WIDTH'(wordIdx) << 2);
                        bus.memData <= packWord;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    bus.memEn <= 1'b0;
                    wordIdx   <= wordIdx + 1'b1;
                    holdCnt   <= '0;
                    if (WIDTH'(wordIdx) == wordCount - 1'b1) begin
                        state <= (RESET_HOLD == 0) ? RUN : HOLD;
                    end else begin
                        state <= LOAD;
                    end
                end
                HOLD: begin
                    if (holdCnt == HOLD_W'(RESET_HOLD - 1)) begin
                        state <= RUN;
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                RUN: begin
                    // A match takes priority over a timeout in the same cycle.
                    if (a0 == expected_a0) begin
                        pass  <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cycles == TIMEOUT_CYCLES) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cycles <= cycles + 1;
                    end
                end
                DONE: state <= DONE;
                ERR:  state <= ERR;
                default: state <= HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a 3-word image with and without
// in_valid gaps, pass and timeout endings, illegal header counts, and a
// mid-load reset followed by a fresh 1-word image.
module tb_program_loader;
    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_reset;
    logic [31:0] a0;
    logic [31:0] expected_a0;
    logic        done, pass, timeout, error;
    logic [31:0] cycles;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int fallCyc = -1;
    logic prevCpuReset = 1'b1;

    logic [31:0] addrQ[$];
    logic [31:0] dataQ[$];
    int          pulseCyc[$];

    logic [31:0] img [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113};

    program_loader_if #(.WIDTH(32)) bus ();

    program_loader #(
        .WIDTH          (32),
        .ADDR_BASE      (32'h0),
        .MAX_WORDS      (1024),
        .RESET_HOLD     (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .cpu_reset   (cpu_reset),
        .a0          (a0),
        .expected_a0 (expected_a0),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .error       (error),
        .cycles      (cycles)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.memEn === 1'b1) begin
            addrQ.push_back(bus.memAddr);
            dataQ.push_back(bus.memData);
            pulseCyc.push_back(cyc);
        end
        if (prevCpuReset === 1'b1 && cpu_reset === 1'b0) fallCyc = cyc;
        prevCpuReset = cpu_reset;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps && $urandom_range(0, 1) == 1) begin
            bus.in_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        @(negedge clock);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (bus.in_ready !== 1'b1) checkVal("byte_accept_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) sendByte(w[i*8 +: 8], gaps);
    endtask

    task automatic sendImage(input bit gaps);
        sendWord(32'd3, gaps);
        for (int i = 0; i < 3; i++) sendWord(img[i], gaps);
        bus.in_valid = 1'b0;
    endtask

    task automatic doReset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        a0           = 32'd0;
        reset        = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        addrQ.delete();
        dataQ.delete();
        pulseCyc.delete();
        fallCyc = -1;
    endtask

    task automatic waitRelease(input string tag);
        int n = 0;
        @(negedge clock);
        while (cpu_reset !== 1'b0 && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (cpu_reset !== 1'b0) checkVal(tag, 32'(cpu_reset), 32'd0);
    endtask

    task automatic checkImage(input string pfx);
        logic [31:0] gotA, gotD;
        checkVal({pfx, "_pulses"}, 32'(addrQ.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            gotA = (i < addrQ.size()) ? addrQ[i] : 32'hxxxx_xxxx;
            gotD = (i < dataQ.size()) ? dataQ[i] : 32'hxxxx_xxxx;
            checkVal($sformatf("%s_addr%0d", pfx, i), gotA, 32'(i * 4));
            checkVal($sformatf("%s_data%0d", pfx, i), gotD, img[i]);
        end
        if (pulseCyc.size() == 3)
            checkVal({pfx, "_release_delay"}, 32'(fallCyc - pulseCyc[2]), 32'd3);
        else
            checkVal({pfx, "_release_delay"}, 32'hxxxx_xxxx, 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        a0           = 32'd0;
        expected_a0  = 32'd144;
        reset        = 1'b1;
        #3;
        checkVal("rst_in_ready",  32'(bus.in_ready), 32'd1);
        checkVal("rst_memEn",     32'(bus.memEn),    32'd0);
        checkVal("rst_memAddr",   bus.memAddr,       32'd0);
        checkVal("rst_memData",   bus.memData,       32'd0);
        checkVal("rst_cpu_reset", 32'(cpu_reset),    32'd1);
        checkVal("rst_flags",     {28'd0, done, pass, timeout, error}, 32'd0);
        checkVal("rst_cycles",    cycles,            32'd0);
        doReset();

        // 1 + 3: back-to-back stream, then a0 match five cycles after release
        sendImage(1'b0);
        waitRelease("t1_release");
        checkVal("t1_cycles_at_release", cycles, 32'd0);
        repeat (5) @(posedge clock);
        #1 a0 = 32'd144;
        @(negedge clock);
        checkVal("t3_done_before", 32'(done),   32'd0);
        checkVal("t3_cycles_now",  cycles,      32'd5);
        @(negedge clock);
        checkVal("t3_done",    32'(done),    32'd1);
        checkVal("t3_pass",    32'(pass),    32'd1);
        checkVal("t3_timeout", 32'(timeout), 32'd0);
        checkVal("t3_cycles",  cycles,       32'd5);
        a0 = 32'd7;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (5) @(negedge clock);
        checkVal("t3_hold_pass",     32'(pass),         32'd1);
        checkVal("t3_hold_cycles",   cycles,            32'd5);
        checkVal("t3_hold_cpu_rst",  32'(cpu_reset),    32'd0);
        checkVal("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        checkImage("t1");

        // 2 + 4: same stream with gaps, a0 never matches
        doReset();
        sendImage(1'b1);
        waitRelease("t2_release");
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            n++;
            @(negedge clock);
        end
        checkVal("t4_done",    32'(done),    32'd1);
        checkVal("t4_timeout", 32'(timeout), 32'd1);
        checkVal("t4_pass",    32'(pass),    32'd0);
        checkVal("t4_cycles",  cycles,       32'd20);
        checkImage("t2");

        // 5: illegal counts 0 and MAX_WORDS+1
        for (int k = 0; k < 2; k++) begin
            doReset();
            sendWord((k == 0) ? 32'd0 : 32'd1025, 1'b0);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA5;
            repeat (6) @(negedge clock);
            bus.in_valid = 1'b0;
            checkVal($sformatf("t5_error%0d", k),    32'(error),        32'd1);
            checkVal($sformatf("t5_cpu_rst%0d", k),  32'(cpu_reset),    32'd1);
            checkVal($sformatf("t5_in_ready%0d", k), 32'(bus.in_ready), 32'd0);
            checkVal($sformatf("t5_no_memEn%0d", k), 32'(addrQ.size()), 32'd0);
        end

        // 6: async reset drops an active write strobe
        doReset();
        sendWord(32'd3, 1'b0);
        sendWord(32'h1122_3344, 1'b0);
        bus.in_valid = 1'b0;
        checkVal("t6_memEn_up", 32'(bus.memEn), 32'd1);
        reset = 1'b1;
        #1;
        checkVal("t6_memEn_async", 32'(bus.memEn), 32'd0);

        // 6: reset after 6 bytes, then a fresh 1-word image
        doReset();
        sendWord(32'd3, 1'b0);
        sendByte(8'hAA, 1'b0);
        sendByte(8'hBB, 1'b0);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkVal("t6_memEn_rst",    32'(bus.memEn),    32'd0);
        checkVal("t6_in_ready_rst", 32'(bus.in_ready), 32'd1);
        doReset();
        sendWord(32'd1, 1'b0);
        sendWord(32'hDEAD_BEEF, 1'b0);
        bus.in_valid = 1'b0;
        waitRelease("t6_release");
        repeat (2) @(negedge clock);
        checkVal("t6_pulses", 32'(addrQ.size()), 32'd1);
        checkVal("t6_addr", (addrQ.size() > 0) ? addrQ[0] : 32'hxxxx_xxxx, 32'h0);
        checkVal("t6_data", (dataQ.size() > 0) ? dataQ[0] : 32'hxxxx_xxxx, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
